// File: rtl/alu_issue_sequencer_if.sv
// Request/ALU/result signal bundle between an issuing master and the ALU issue sequencer.
interface alu_issue_sequencer_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [10:0]       Opcode;
  logic [1:0]        ALUOp;
  logic [DATA_W-1:0] OpA;
  logic [DATA_W-1:0] OpB;
  logic [DATA_W-1:0] BusA;
  logic [DATA_W-1:0] BusB;
  logic [3:0]        ALUCtrl;
  logic [DATA_W-1:0] BusW;
  logic              Zero;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] Result;
  logic              ResultZero;
  logic              Err;

  modport slave (
    input  in_valid, Opcode, ALUOp, OpA, OpB, BusW, Zero, out_ready,
    output in_ready, BusA, BusB, ALUCtrl, out_valid, Result, ResultZero, Err
  );

  modport master (
    output in_valid, Opcode, ALUOp, OpA, OpB, BusW, Zero, out_ready,
    input  in_ready, BusA, BusB, ALUCtrl, out_valid, Result, ResultZero, Err
  );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Registers operands and decoded ALU code, waits SETTLE cycles, captures BusW/Zero; legal latency SETTLE+1 edges, illegal 1.
// Result is held in DONE until out_ready; no new request is accepted outside IDLE.
module alu_issue_sequencer #(
  parameter int DATA_W = 64,
  parameter int SETTLE = 1
) (
  input  logic                  CLK,
  input  logic                  Reset_L,
  alu_issue_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_ORR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_PASB = 4'b0111;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_bus_a;
  logic [DATA_W-1:0] r_bus_b;
  logic [3:0]        r_ctrl;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_err;

  logic              w_legal;
  logic [3:0]        w_ctrl;

  always_comb begin
    w_legal = 1'b1;
    w_ctrl  = CTRL_AND;
    case (bus.ALUOp)
      2'b00: w_ctrl = CTRL_ADD;
      2'b01: w_ctrl = CTRL_PASB;
      2'b10: begin
        case (bus.Opcode)
          11'b10001011000: w_ctrl = CTRL_ADD;
          11'b11001011000: w_ctrl = CTRL_SUB;
          11'b10001010000: w_ctrl = CTRL_AND;
          11'b10101010000: w_ctrl = CTRL_ORR;
          default:         w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_bus_a  <= '0;
      r_bus_b  <= '0;
      r_ctrl   <= 4'b0000;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            if (w_legal) begin
              r_bus_a <= bus.OpA;
              r_bus_b <= bus.OpB;
              r_ctrl  <= w_ctrl;
              r_cnt   <= SETTLE_LD;
              r_state <= ISSUE;
            end else begin
              // Illegal requests leave the ALU bus untouched and report straight away.
              r_result <= '0;
              r_zero   <= 1'b0;
              r_err    <= 1'b1;
              r_state  <= DONE;
            end
          end
        end
        ISSUE: begin
          if (r_cnt == 4'd0) begin
            r_result <= bus.BusW;
            r_zero   <= bus.Zero;
            r_err    <= 1'b0;
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gated with Reset_L so nothing is offered while reset is held.
  assign bus.in_ready   = Reset_L && (r_state == IDLE);
  assign bus.out_valid  = (r_state == DONE);
  assign bus.BusA       = r_bus_a;
  assign bus.BusB       = r_bus_b;
  assign bus.ALUCtrl    = r_ctrl;
  assign bus.Result     = r_result;
  assign bus.ResultZero = r_zero;
  assign bus.Err        = r_err;

endmodule

// File: doc/alu_issue_sequencer.md
ALU_ISSUE_SEQUENCER -- requirements
Module: alu_issue_sequencer

Interface
REQ-001 Parameter: DATA_W, default 64, operand/result width.
REQ-002 Parameter: SETTLE, default 1, cycles ALU inputs are held before BusW/Zero are sampled; legal range 1..15.
REQ-003 Port: CLK  input  1  rising-edge clock.
REQ-004 Port: Reset_L  input  1  reset; one clock, synchronous, active-low.
REQ-005 Port: in_valid  input  1  request present.
REQ-006 Port: in_ready  output  1  sequencer accepts a request this cycle.
REQ-007 Port: Opcode  input  11  ARMv8 R-type opcode field.
REQ-008 Port: ALUOp  input  2  main-control ALU operation class.
REQ-009 Port: OpA, OpB  input  DATA_W each  source operands.
REQ-010 Port: BusA, BusB  output  DATA_W each  registered operands to ALU.
REQ-011 Port: ALUCtrl  output  4  registered ALU function code to ALU.
REQ-012 Port: BusW  input  DATA_W  ALU result.
REQ-013 Port: Zero  input  1  ALU zero flag.
REQ-014 Port: out_valid  output  1  result available.
REQ-015 Port: out_ready  input  1  consumer takes result.
REQ-016 Port: Result  output  DATA_W  captured BusW.
REQ-017 Port: ResultZero  output  1  captured Zero.
REQ-018 Port: Err  output  1  request had an illegal ALUOp/Opcode combination.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, DONE; in_ready SHALL be 1 only in IDLE.
REQ-020 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; OpA, OpB register into BusA, BusB and the decoded code into ALUCtrl on that edge.
REQ-021 Decode: ALUOp=00 -> 0010 (ADD); ALUOp=01 -> 0111 (PassB); ALUOp=10 with Opcode 10001011000 -> 0010, 11001011000 -> 0110, 10001010000 -> 0000, 10101010000 -> 0001.
REQ-022 ALUOp=11, or ALUOp=10 with any other Opcode, SHALL be illegal: BusA/BusB/ALUCtrl unchanged, FSM IDLE -> DONE on the accept edge, Result=0, ResultZero=0, Err=1.
REQ-023 Legal accept: IDLE -> ISSUE; a 4-bit settle counter loads SETTLE-1 and decrements each edge in ISSUE.
REQ-024 On the ISSUE edge where the counter equals 0, BusW -> Result, Zero -> ResultZero, Err=0, FSM -> DONE; legal-request latency is SETTLE+1 edges from accept to out_valid=1.
REQ-025 out_valid SHALL be 1 exactly while in DONE; Result, ResultZero, Err SHALL be stable in DONE.
REQ-026 DONE with out_ready=1 SHALL return to IDLE on that edge; out_ready=0 holds DONE indefinitely; in_valid is ignored outside IDLE.
REQ-027 No back-to-back bypass: after DONE->IDLE, the next accept occurs no earlier than the following edge.
REQ-028 BusA, BusB, ALUCtrl SHALL hold their last issued values in DONE and IDLE until the next legal accept.
REQ-029 Arithmetic is entirely in the ALU; the sequencer SHALL not modify BusW or Zero, and overflow/wrap follows the ALU's DATA_W result unchanged.
REQ-030 out_ready while not in DONE SHALL have no effect.

Reset
REQ-031 Reset_L=0 sampled on a rising edge SHALL force FSM=IDLE, counter=0, BusA=BusB=0, ALUCtrl=0000, Result=0, ResultZero=0, Err=0, out_valid=0.
REQ-032 in_ready SHALL be 0 while Reset_L=0 and 1 on the first cycle after release.
REQ-033 Reset in ISSUE or DONE SHALL discard the in-flight request with no out_valid pulse; reset takes priority over accept and out_ready on the same edge.

Verification
REQ-034 ADD: SETTLE=1, ALUOp=10, Opcode=10001011000, OpA=5, OpB=7 -> ALUCtrl=0010, out_valid on 2nd edge after accept, Result=12, ResultZero=0, Err=0.
REQ-035 SUB zero: SETTLE=3, Opcode=11001011000, OpA=OpB=0x1234 -> ALUCtrl=0110, out_valid 4 edges after accept, Result=0, ResultZero=1.
REQ-036 Illegal: ALUOp=11 -> out_valid one edge after accept, Err=1, Result=0, BusA/BusB/ALUCtrl unchanged from previous request.
REQ-037 Backpressure: ALUOp=01, OpB=0xFFFF_FFFF_FFFF_FFFF, out_ready=0 for 5 cycles -> out_valid, Result stable, in_ready=0 throughout; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-038 Reset mid-op: Reset_L=0 during ISSUE with SETTLE=4 -> all outputs per REQ-031, no out_valid pulse, next request completes normally.
REQ-039 Wrap: ADD with OpA=0xFFFF_FFFF_FFFF_FFFF, OpB=1 -> Result=0, ResultZero=1, Err=0.
